// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle controller: opcode/function codes,
// branch-compare encodings and the controller state enum.
package mc_pkg;

    // Opcode field values
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_BLT   = 6'b000110;

    // R-type function field values
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_NOR = 6'b100111;

    // Branch compare select
    localparam logic [1:0] BR_NONE = 2'b00;
    localparam logic [1:0] BR_EQ   = 2'b01;
    localparam logic [1:0] BR_NE   = 2'b10;
    localparam logic [1:0] BR_LT   = 2'b11;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_ERR    = 3'd5
    } mc_state_e;

    // True for the R-type function codes the datapath implements.
    function automatic logic fn_legal(input logic [5:0] f);
        return (f == FN_ADD) || (f == FN_SUB) || (f == FN_SLT) || (f == FN_AND) ||
               (f == FN_OR)  || (f == FN_XOR) || (f == FN_NOR);
    endfunction

endpackage

// File: rtl/mc_ctrl_if.sv
// Controller <-> datapath/memory bundle. The controller side is "master".
// Memory handshake: mem_req (with rd or we) is held stable by the controller
// until a cycle in which mem_ready is high; that cycle completes the access.
// mem_ready is ignored whenever mem_req is low.
interface mc_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       opcode;
    logic [5:0]       fn;
    logic             brtrue;
    logic             mem_ready;
    logic             ir_we;
    logic             pc_we;
    logic             pc_src;
    logic             alusrc;
    logic [1:0]       brtype;
    logic             rd;
    logic             we;
    logic             mem_req;
    logic             reg_we;
    logic             mem_to_reg;
    logic             err;
    logic [CNT_W-1:0] retired;

    modport master (
        input  opcode, fn, brtrue, mem_ready,
        output ir_we, pc_we, pc_src, alusrc, brtype, rd, we, mem_req,
               reg_we, mem_to_reg, err, retired
    );

    modport slave (
        output opcode, fn, brtrue, mem_ready,
        input  ir_we, pc_we, pc_src, alusrc, brtype, rd, we, mem_req,
               reg_we, mem_to_reg, err, retired
    );
endinterface

// File: rtl/mc_decode.sv
// Combinational opcode/function decoder for the multi-cycle controller.
// Optional macro MC_CTRL_ILLEGAL_TRAP_EN: when defined, R-type instructions
// are legal only for the implemented function codes.
module mc_decode
    import mc_pkg::*;
(
    input  logic [5:0] opcode_i,
    input  logic [5:0] fn_i,
    output logic       alusrc_o,
    output logic [1:0] brtype_o,
    output logic       is_load_o,
    output logic       is_store_o,
    output logic       is_branch_o,
    output logic       legal_o
);

    // Classify the latched instruction
    always_comb begin
        alusrc_o    = 1'b0;
        brtype_o    = BR_NONE;
        is_load_o   = 1'b0;
        is_store_o  = 1'b0;
        is_branch_o = 1'b0;
        legal_o     = 1'b0;
        case (opcode_i)
            OP_LW: begin
                alusrc_o  = 1'b1;
                is_load_o = 1'b1;
                legal_o   = 1'b1;
            end
            OP_SW: begin
                alusrc_o   = 1'b1;
                is_store_o = 1'b1;
                legal_o    = 1'b1;
            end
            OP_ADDI, OP_ANDI, OP_ORI, OP_XORI: begin
                alusrc_o = 1'b1;
                legal_o  = 1'b1;
            end
            OP_RTYPE: begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                legal_o = fn_legal(fn_i);
`else
                legal_o = 1'b1;
`endif
            end
            OP_BEQ: begin
                brtype_o    = BR_EQ;
                is_branch_o = 1'b1;
                legal_o     = 1'b1;
            end
            OP_BNE: begin
                brtype_o    = BR_NE;
                is_branch_o = 1'b1;
                legal_o     = 1'b1;
            end
            OP_BLT: begin
                brtype_o    = BR_LT;
                is_branch_o = 1'b1;
                legal_o     = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle processor controller: FETCH/DECODE/EXEC/MEM/WB sequencing with
// a memory-wait timeout into a sticky ERR state and a retired-instruction
// counter. Optional macro MC_CTRL_ILLEGAL_TRAP_EN sends illegal instructions
// to ERR instead of retiring them as no-ops.
module mc_ctrl
    import mc_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic      clk,
    input  logic      rst,
    mc_ctrl_if.master bus,
    output mc_state_e state_o
);

    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    mc_state_e        state_q, state_d;
    logic [5:0]       opcode_q, fn_q;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0] retired_q;
    logic             err_q;
    logic             retire;

    logic       dec_alusrc, dec_is_load, dec_is_store, dec_is_branch, dec_legal;
    logic [1:0] dec_brtype;

    mc_decode u_decode (
        .opcode_i    (opcode_q),
        .fn_i        (fn_q),
        .alusrc_o    (dec_alusrc),
        .brtype_o    (dec_brtype),
        .is_load_o   (dec_is_load),
        .is_store_o  (dec_is_store),
        .is_branch_o (dec_is_branch),
        .legal_o     (dec_legal)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_FETCH;
        else     state_q <= state_d;
    end

    // Next state, wait counter and retire decision
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        retire  = 1'b0;
        case (state_q)
            ST_FETCH: begin
                if (bus.mem_ready)          state_d = ST_DECODE;
                else if (wait_q == WAIT_LAST) state_d = ST_ERR;
                else                        wait_d = wait_q + WAIT_W'(1);
            end
            ST_DECODE: state_d = ST_EXEC;
            ST_EXEC: begin
                if (dec_is_branch) begin
                    state_d = ST_FETCH;
                    retire  = 1'b1;
                end else if (dec_is_load || dec_is_store) begin
                    state_d = ST_MEM;
                end else if (dec_legal) begin
                    state_d = ST_WB;
                end else begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                    state_d = ST_ERR;
`else
                    state_d = ST_FETCH;
                    retire  = 1'b1;
`endif
                end
            end
            ST_MEM: begin
                if (bus.mem_ready) begin
                    if (dec_is_load) begin
                        state_d = ST_WB;
                    end else begin
                        state_d = ST_FETCH;
                        retire  = 1'b1;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    state_d = ST_ERR;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            ST_WB: begin
                state_d = ST_FETCH;
                retire  = 1'b1;
            end
            ST_ERR:  state_d = ST_ERR;
            default: state_d = ST_ERR;
        endcase
        // Every state change lands in a fresh wait window.
        if (state_d != state_q) wait_d = '0;
    end

    // Instruction latch, wait counter, retired counter and sticky error
    always_ff @(posedge clk) begin
        if (rst) begin
            opcode_q  <= '0;
            fn_q      <= '0;
            wait_q    <= '0;
            retired_q <= '0;
            err_q     <= 1'b0;
        end else begin
            wait_q <= wait_d;
            if (state_q == ST_DECODE) begin
                opcode_q <= bus.opcode;
                fn_q     <= bus.fn;
            end
            if (retire) retired_q <= retired_q + CNT_W'(1);
            if (state_d == ST_ERR) err_q <= 1'b1;
        end
    end

    // Strobes decoded from state and latched instruction; silenced during reset
    always_comb begin
        bus.ir_we      = 1'b0;
        bus.pc_we      = 1'b0;
        bus.pc_src     = 1'b0;
        bus.alusrc     = 1'b0;
        bus.brtype     = BR_NONE;
        bus.rd         = 1'b0;
        bus.we         = 1'b0;
        bus.mem_req    = 1'b0;
        bus.reg_we     = 1'b0;
        bus.mem_to_reg = 1'b0;
        if (!rst) begin
            case (state_q)
                ST_FETCH: begin
                    bus.mem_req = 1'b1;
                    bus.rd      = 1'b1;
                    if (bus.mem_ready) begin
                        bus.ir_we = 1'b1;
                        bus.pc_we = 1'b1;
                    end
                end
                ST_EXEC: begin
                    bus.alusrc = dec_alusrc;
                    bus.brtype = dec_brtype;
                    if (dec_is_branch) begin
                        bus.pc_src = 1'b1;
                        bus.pc_we  = bus.brtrue;
                    end
                end
                ST_MEM: begin
                    bus.mem_req = 1'b1;
                    bus.rd      = dec_is_load;
                    bus.we      = dec_is_store;
                end
                ST_WB: begin
                    bus.reg_we     = 1'b1;
                    bus.mem_to_reg = dec_is_load;
                end
                default: ;
            endcase
        end
    end

    assign bus.err     = err_q;
    assign bus.retired = retired_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: directed scenarios plus randomized
// instruction streams compared cycle by cycle against an instruction-level model.
module tb_mc_ctrl;
  import mc_pkg::*;

  localparam int TO = 16;
  localparam int CW = 4;

  // output vector bit masks: {ir_we,pc_we,pc_src,alusrc,brtype[1:0],rd,we,mem_req,reg_we,mem_to_reg,err}
  localparam logic [11:0] E_IR   = 12'h800;
  localparam logic [11:0] E_PCWE = 12'h400;
  localparam logic [11:0] E_PCS  = 12'h200;
  localparam logic [11:0] E_ALU  = 12'h100;
  localparam logic [11:0] E_RD   = 12'h020;
  localparam logic [11:0] E_WE   = 12'h010;
  localparam logic [11:0] E_MREQ = 12'h008;
  localparam logic [11:0] E_RWE  = 12'h004;
  localparam logic [11:0] E_M2R  = 12'h002;
  localparam logic [11:0] E_ERR  = 12'h001;

  typedef enum {K_LOAD, K_STORE, K_BR, K_ALU, K_NOP, K_TRAP} kind_e;

  // clock/reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mc_state_e state_dbg;
  mc_ctrl_if #(.CNT_W(CW)) bus ();
  mc_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .bus(bus), .state_o(state_dbg)
  );

  int total = 0;
  int bad = 0;
  int exp_ret = 0;

  task automatic check(input string tag, input logic [31:0] obs_v, input logic [31:0] exp_v);
    total++;
    if (obs_v !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs_v, exp_v);
    end
  endtask

  function automatic logic [11:0] obs();
    return {bus.ir_we, bus.pc_we, bus.pc_src, bus.alusrc, bus.brtype, bus.rd, bus.we,
            bus.mem_req, bus.reg_we, bus.mem_to_reg, bus.err};
  endfunction

  // reference model: instruction class from the opcode/fn tables
  function automatic kind_e classify(input logic [5:0] op, input logic [5:0] f);
    case (op)
      6'b100011: return K_LOAD;
      6'b101011: return K_STORE;
      6'b000100, 6'b000101, 6'b000110: return K_BR;
      6'b001000, 6'b001100, 6'b001101, 6'b001110: return K_ALU;
      6'b000000: begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        if (f inside {6'b100000, 6'b100010, 6'b101010, 6'b100100, 6'b100101, 6'b100110, 6'b100111})
          return K_ALU;
        return K_TRAP;
`else
        return K_ALU;
`endif
      end
      default: begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        return K_TRAP;
`else
        return K_NOP;
`endif
      end
    endcase
  endfunction

  function automatic logic [1:0] br_code(input logic [5:0] op);
    case (op)
      6'b000100: return 2'b01;
      6'b000101: return 2'b10;
      6'b000110: return 2'b11;
      default:   return 2'b00;
    endcase
  endfunction

  // One clock cycle: inputs already driven; check, advance, account retirement.
  task automatic cyc(input string tag, input logic [11:0] e, input mc_state_e est, input bit ret);
    #2;
    check({tag, ":out"}, 32'(obs()), 32'(e));
    check({tag, ":state"}, 32'(state_dbg), 32'(est));
    check({tag, ":retired"}, 32'(bus.retired), 32'(exp_ret));
    @(posedge clk); #1;
    if (ret) exp_ret = (exp_ret + 1) % (1 << CW);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.mem_ready = 1'($urandom_range(0, 1));
    bus.opcode = 6'($urandom);
    bus.brtrue = 1'($urandom_range(0, 1));
    #2;
    check("rst_strobes", 32'(obs() & ~E_ERR), 32'd0);
    @(posedge clk); #1;
    exp_ret = 0;
    cyc("rst_hold", 12'h000, ST_FETCH, 1'b0);
    rst = 1'b0;
    bus.mem_ready = 1'b0;
  endtask

  // FETCH (fd waits), DECODE, EXEC; returns the instruction class.
  task automatic front(input logic [5:0] op, input logic [5:0] f, input bit bt, input int fd,
                       output kind_e k);
    logic [11:0] ex;
    k = classify(op, f);
    for (int i = 0; i < fd; i++) begin
      bus.mem_ready = 1'b0;
      bus.brtrue = 1'($urandom_range(0, 1));
      bus.opcode = 6'($urandom);
      cyc("fetch_wait", E_RD | E_MREQ, ST_FETCH, 1'b0);
    end
    bus.mem_ready = 1'b1;
    cyc("fetch_rdy", E_IR | E_PCWE | E_RD | E_MREQ, ST_FETCH, 1'b0);
    bus.opcode = op;
    bus.fn = f;
    bus.mem_ready = 1'($urandom_range(0, 1));
    bus.brtrue = 1'($urandom_range(0, 1));
    cyc("decode", 12'h000, ST_DECODE, 1'b0);
    bus.opcode = 6'($urandom);
    bus.fn = 6'($urandom);
    bus.brtrue = bt;
    bus.mem_ready = 1'($urandom_range(0, 1));
    ex = 12'h000;
    if (k == K_LOAD || k == K_STORE || (k == K_ALU && op != 6'b000000)) ex = ex | E_ALU;
    if (k == K_BR) begin
      ex[7:6] = br_code(op);
      ex = ex | E_PCS;
      if (bt) ex = ex | E_PCWE;
    end
    cyc("exec", ex, ST_EXEC, (k == K_BR) || (k == K_NOP));
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] f, input bit bt,
                           input int fd, input int md, output bit trapped);
    kind_e k;
    logic [11:0] ex;
    trapped = 1'b0;
    front(op, f, bt, fd, k);
    if (k == K_TRAP) begin
      bus.mem_ready = 1'($urandom_range(0, 1));
      cyc("trap", E_ERR, ST_ERR, 1'b0);
      trapped = 1'b1;
      return;
    end
    if (k == K_LOAD || k == K_STORE) begin
      ex = E_MREQ | ((k == K_LOAD) ? E_RD : E_WE);
      for (int i = 0; i < md; i++) begin
        bus.mem_ready = 1'b0;
        cyc("mem_wait", ex, ST_MEM, 1'b0);
      end
      bus.mem_ready = 1'b1;
      cyc("mem_rdy", ex, ST_MEM, k == K_STORE);
    end
    if (k == K_LOAD || k == K_ALU) begin
      bus.mem_ready = 1'($urandom_range(0, 1));
      cyc("wb", E_RWE | ((k == K_LOAD) ? E_M2R : 12'h000), ST_WB, 1'b1);
    end
    bus.mem_ready = 1'b0;
  endtask

  logic [5:0] op_tab [12] = '{6'b000000, 6'b100011, 6'b101011, 6'b001000, 6'b001100, 6'b001101,
                              6'b001110, 6'b000100, 6'b000101, 6'b000110, 6'b111111, 6'b010000};
  logic [5:0] fn_tab [7] = '{6'b100000, 6'b100010, 6'b101010, 6'b100100, 6'b100101, 6'b100110, 6'b100111};

  initial begin
    bit tr;
    kind_e k;
    logic [5:0] op, f;
    bus.opcode = '0; bus.fn = '0; bus.brtrue = 1'b0; bus.mem_ready = 1'b0;
    do_reset();

    // directed
    run_instr(6'b001000, 6'h00, 1'b0, 0, 0, tr);        // addi
    run_instr(6'b100011, 6'h00, 1'b0, 2, 3, tr);        // lw, 3 wait cycles
    run_instr(6'b000100, 6'h00, 1'b1, 0, 0, tr);        // beq taken
    run_instr(6'b000100, 6'h00, 1'b0, 1, 0, tr);        // beq not taken
    run_instr(6'b000101, 6'h00, 1'b1, 0, 0, tr);        // bne
    run_instr(6'b000110, 6'h00, 1'b1, 0, 0, tr);        // blt
    run_instr(6'b101011, 6'h00, 1'b0, TO - 1, TO - 1, tr); // longest legal waits
    run_instr(6'b000000, 6'b100000, 1'b0, 0, 0, tr);    // add
    run_instr(6'b111111, 6'h00, 1'b0, 0, 0, tr);        // unlisted opcode
    if (tr) begin
      check("trap_err", 32'(bus.err), 32'd1);
      do_reset();
    end

    // randomized stream
    for (int n = 0; n < 80; n++) begin
      op = op_tab[$urandom_range(0, 11)];
      if ($urandom_range(0, 7) == 0) op = 6'($urandom);
      f = fn_tab[$urandom_range(0, 6)];
      if ($urandom_range(0, 5) == 0) f = 6'($urandom);
      run_instr(op, f, 1'($urandom_range(0, 1)),
                ($urandom_range(0, 3) == 0) ? $urandom_range(0, TO - 1) : $urandom_range(0, 2),
                ($urandom_range(0, 3) == 0) ? $urandom_range(0, TO - 1) : $urandom_range(0, 2), tr);
      if (tr) do_reset();
    end

    // reset in the middle of a store's memory phase
    front(6'b101011, 6'h00, 1'b0, 1, k);
    bus.mem_ready = 1'b0;
    cyc("sw_mem", E_MREQ | E_WE, ST_MEM, 1'b0);
    cyc("sw_mem", E_MREQ | E_WE, ST_MEM, 1'b0);
    do_reset();
    check("after_rst_err", 32'(bus.err), 32'd0);
    run_instr(6'b001101, 6'h00, 1'b0, 0, 0, tr);

    // store whose memory never answers: timeout into ERR
    front(6'b101011, 6'h00, 1'b0, 0, k);
    for (int i = 0; i < TO; i++) begin
      bus.mem_ready = 1'b0;
      cyc("sw_to_mem", E_MREQ | E_WE, ST_MEM, 1'b0);
    end
    for (int i = 0; i < 3; i++) begin
      bus.mem_ready = 1'($urandom_range(0, 1));
      bus.brtrue = 1'($urandom_range(0, 1));
      cyc("sw_to_err", E_ERR, ST_ERR, 1'b0);
    end
    do_reset();

    // fetch timeout
    for (int i = 0; i < TO; i++) begin
      bus.mem_ready = 1'b0;
      cyc("fetch_to", E_RD | E_MREQ, ST_FETCH, 1'b0);
    end
    bus.mem_ready = 1'b1;
    cyc("fetch_to_err", E_ERR, ST_ERR, 1'b0);
    do_reset();
    run_instr(6'b001000, 6'h00, 1'b0, 0, 0, tr);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 16, max cycles waited for mem_ready in any wait state.
REQ-002 SHALL have parameter CNT_W, default 32, width of retired-instruction counter.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 opcode  in  6  instruction opcode field from instruction bus.
REQ-006 fn  in  6  R-type function field.
REQ-007 brtrue  in  1  branch-condition result from ALU.
REQ-008 mem_ready  in  1  memory handshake: access complete this cycle.
REQ-009 ir_we, pc_we, pc_src  out  1 each  instruction-register load, PC load, PC source (0 = PC+4, 1 = branch target).
REQ-010 alusrc  out  1  ALU operand B select (1 = sign-extended imm).
REQ-011 brtype  out  2  branch compare select (01 eq, 10 ne, 11 lt, 00 none).
REQ-012 rd, we  out  1 each  memory read, memory write strobes.
REQ-013 mem_req, reg_we, mem_to_reg  out  1 each  memory request, register-file write, writeback source (1 = memory data).
REQ-014 err  out  1  sticky fault flag.
REQ-015 retired  out  CNT_W  count of completed instructions.

Function
REQ-016 SHALL be an FSM with states FETCH, DECODE, EXEC, MEM, WB, ERR; outputs Moore-decoded from state and latched opcode/fn.
REQ-017 FETCH: mem_req=1, rd=1; on mem_ready assert ir_we and pc_we (pc_src=0) for that cycle and go DECODE; else stay.
REQ-018 DECODE: latch opcode and fn (one cycle); go EXEC.
REQ-019 EXEC: alusrc=1 for 100011, 101011, 001000, 001100, 001101, 001110; alusrc=0 for 000000 and branches.
REQ-020 EXEC branches: 000100 -> brtype 01, 000101 -> 10, 000110 -> 11; pc_we=brtrue, pc_src=1; next FETCH; retired increments.
REQ-021 EXEC next state: 100011/101011 -> MEM; 000000 and ALU-immediate -> WB.
REQ-022 MEM: mem_req=1; rd=1 for 100011, we=1 for 101011, held stable until mem_ready; on mem_ready lw -> WB, sw -> FETCH with retired increment.
REQ-023 WB: reg_we=1 for exactly one cycle, mem_to_reg=1 only for 100011; next FETCH; retired increments.
REQ-024 Strobes rd/we/reg_we/pc_we/ir_we SHALL never assert in a state not listed above for them.
REQ-025 Wait counter resets on entry to FETCH/MEM; if MEM_TIMEOUT cycles elapse without mem_ready, go ERR, set err=1.
REQ-026 ERR: all strobes 0, mem_req 0; remain until rst.
REQ-027 mem_ready outside FETCH/MEM SHALL be ignored.
REQ-028 retired SHALL wrap modulo 2^CNT_W without flagging.
REQ-029 Unlisted opcodes SHALL be treated as no-op: EXEC -> FETCH, retired increments.

Reset
REQ-030 rst SHALL force state FETCH, latched opcode/fn 0, wait counter 0, retired 0, err 0; all strobes 0 in the reset cycle.
REQ-031 rst mid-MEM SHALL drop rd/we/mem_req on the next edge; no partial write completion is signalled.

Configuration
REQ-032 With MC_CTRL_ILLEGAL_TRAP_EN defined, unlisted opcodes (and 000000 with fn outside 100000, 100010, 101010, 100100, 100101, 100110, 100111) SHALL go EXEC -> ERR with err=1, retired unchanged.
REQ-033 Without MC_CTRL_ILLEGAL_TRAP_EN, REQ-029 applies and fn is not checked.

Structure
REQ-034 Opcode/fn constants, brtype encodings and state enum SHALL live in shared package mc_pkg.
REQ-035 Opcode decode SHALL be sub-module mc_decode (combinational: opcode, fn -> alusrc, brtype, is_load, is_store, is_branch, legal).

Verification
REQ-036 addi (001000), mem_ready in first FETCH cycle -> FETCH, DECODE, EXEC (alusrc=1), WB (reg_we=1, mem_to_reg=0); retired=1 after 4 cycles.
REQ-037 lw (100011), mem_ready delayed 3 cycles in MEM -> rd=1 held 4 cycles, then WB mem_to_reg=1; retired=1.
REQ-038 beq (000100) with brtrue=1 -> brtype=01, pc_we=1, pc_src=1 in EXEC; brtrue=0 -> pc_we=0; both retire.
REQ-039 sw (101011), mem_ready never asserted, MEM_TIMEOUT=16 -> ERR after 16 MEM cycles, err=1, we=0 thereafter.
REQ-040 opcode 111111 -> with MC_CTRL_ILLEGAL_TRAP_EN err=1, retired=0; without it FETCH resumes, retired=1.
REQ-041 rst asserted in MEM of sw -> next cycle state FETCH, we=0, retired=0, err=0.
